// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the CPU DM stage and a host burst port
module dmem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [3:0]        host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {CPU_OWN, HOST_BURST} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [3:0]        beat_q, beat_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, rvalid_q, rvalid_d;
  logic              cpu_acc, burst, gnt, last;
  logic [3:0]        len_cap;
  assign cpu_acc = cpu_re | cpu_we;
  assign burst   = state_q == HOST_BURST;
  assign len_cap = host_len > 4'(BURST_MAX - 1) ? 4'(BURST_MAX - 1) : host_len;
  assign gnt     = !burst && host_req && (!cpu_acc || starve_q == SW'(STARVE_MAX));
  assign last    = burst && beat_q == len_q;
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    len_d    = len_q;
    addr_d   = addr_q;
    we_d     = we_q;
    rvalid_d = burst && !we_q;
    if (!burst) begin
      starve_d = (host_req && cpu_acc && !gnt) ? starve_q + 1'b1 : '0;
      state_d  = gnt ? HOST_BURST : CPU_OWN;
      beat_d   = '0;
      len_d    = gnt ? len_cap : len_q;
      addr_d   = gnt ? host_addr : addr_q;
      we_d     = gnt ? host_we : we_q;
    end else begin
      state_d = last ? CPU_OWN : HOST_BURST;
      beat_d  = last ? '0 : beat_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CPU_OWN;
      starve_q <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
    end
  end
  // every output is held at zero while reset is asserted, including the memory strobes
  always_comb begin
    cpu_rdata   = '0;
    cpu_stall   = 1'b0;
    host_gnt    = 1'b0;
    host_ack    = 1'b0;
    host_rdata  = '0;
    host_rvalid = 1'b0;
    host_done   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    if (rst_n) begin
      cpu_rdata   = mem_rdata;
      host_rdata  = mem_rdata;
      host_rvalid = rvalid_q;
      host_gnt    = gnt;
      host_ack    = burst;
      host_done   = last;
      cpu_stall   = burst ? cpu_acc : gnt && cpu_acc;
      mem_addr    = burst ? addr_q + ADDR_W'(beat_q) : cpu_addr;
      mem_wdata   = burst ? host_wdata : cpu_wdata;
      mem_re      = burst ? !we_q : cpu_re && !gnt;
      mem_we      = burst ? we_q : cpu_we && !gnt;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized scoreboard bench against a beat-list reference model
module tb_dmem_port_arbiter;
  localparam int STARVE = 4;
  localparam int BMAX   = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_re = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
  logic [3:0]  host_len = 0;
  logic [15:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        cpu_stall, host_gnt, host_ack, host_rvalid, host_done, mem_re, mem_we;
  always #5 clk = ~clk;
  dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_done(host_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end
  typedef struct packed {
    logic gnt, stall, re, we, ack, done, rvalid, chk_c;
    logic [15:0] addr, wd, cval;
  } exp_t;
  typedef struct packed {logic [15:0] addr; logic we;} beat_t;
  exp_t        eq[$];
  beat_t       bq[$];
  logic [15:0] hq[$];
  int          n_chk = 0, n_pass = 0, cyc_no = 0, m_starve = 0;
  bit          m_prev_read = 0, m_prev_cload = 0, hold = 0;
  logic [15:0] m_prev_cval = 0;
  task automatic cyc(input bit rs, re, we, input logic [15:0] ca, cd, input bit hr, hw,
                     input logic [15:0] ha, input logic [3:0] hl, input logic [15:0] hd);
    exp_t  e;
    beat_t b;
    bit    acc, g;
    int    n;
    @(posedge clk);
    #1;
    rst_n = !rs; cpu_re = re; cpu_we = we; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_len = hl; host_wdata = hd;
    cyc_no++;
    e = '0;
    if (rs) begin
      bq.delete(); hq.delete();
      m_starve = 0; m_prev_read = 0; m_prev_cload = 0;
    end else begin
      e.rvalid = m_prev_read; e.chk_c = m_prev_cload; e.cval = m_prev_cval;
      m_prev_read = 0; m_prev_cload = 0;
      if (bq.size() == 0) begin
        acc = re || we;
        g = hr && (!acc || m_starve == STARVE);
        e.gnt = g; e.stall = g && acc;
        if (!g && acc) begin
          e.re = re; e.we = we; e.addr = ca;
          if (we) begin e.wd = cd; ref_mem[ca] = cd; end
          if (re) begin m_prev_cload = 1; m_prev_cval = ref_mem[ca]; end
        end
        if (g) begin
          n = (int'(hl) > BMAX - 1) ? BMAX : int'(hl) + 1;
          for (int i = 0; i < n; i++) begin b.addr = ha + 16'(i); b.we = hw; bq.push_back(b); end
          m_starve = 0;
        end else m_starve = (hr && acc) ? m_starve + 1 : 0;
      end else begin
        b = bq.pop_front();
        e.ack = 1; e.done = bq.size() == 0; e.stall = re || we;
        e.addr = b.addr; e.we = b.we; e.re = !b.we;
        if (b.we) begin e.wd = hd; ref_mem[b.addr] = hd; end
        else begin hq.push_back(ref_mem[b.addr]); m_prev_read = 1; end
      end
    end
    eq.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
  endtask
  exp_t        me;
  logic [38:0] act, ex;
  logic [15:0] hv;
  always @(negedge clk) begin
    if (eq.size() != 0) begin
      me  = eq.pop_front();
      act = {host_gnt, cpu_stall, mem_re, mem_we, host_ack, host_done, host_rvalid,
             (mem_re | mem_we) ? mem_addr : 16'h0, mem_we ? mem_wdata : 16'h0};
      ex  = {me.gnt, me.stall, me.re, me.we, me.ack, me.done, me.rvalid, me.addr, me.wd};
      n_chk++;
      if (act === ex) n_pass++;
      else $display("FAIL port cycle %0d: got %h expected %h (gnt,stall,re,we,ack,done,rvalid,addr,wdata)", cyc_no, act, ex);
      if (me.chk_c) begin
        n_chk++;
        if (cpu_rdata === me.cval) n_pass++;
        else $display("FAIL cpu_rdata cycle %0d: got %h expected %h", cyc_no, cpu_rdata, me.cval);
      end
    end
    if (host_rvalid === 1'b1) begin
      n_chk++;
      if (hq.size() == 0) $display("FAIL host_rdata cycle %0d: got rvalid with no read beat pending", cyc_no);
      else begin
        hv = hq.pop_front();
        if (host_rdata === hv) n_pass++;
        else $display("FAIL host_rdata cycle %0d: got %h expected %h", cyc_no, host_rdata, hv);
      end
    end
  end
  initial begin
    int r;
    bit hrand;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    repeat (3) cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    cyc(0, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 4'h0, 16'h0);
    idle(2);
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h00FE, 4'd3, 16'h0);
    idle(6);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 16'(i), 16'h0, 1, 0, 16'h0040, 4'd2, 16'h0);
    idle(3);
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 4'd15, 16'h0);
    idle(10);
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'hFFFF, 4'd1, 16'h1111);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 4'h0, 16'h2222);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 4'h0, 16'h3333);
    cyc(0, 1, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    cyc(0, 1, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    idle(2);
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0200, 4'd5, 16'h0);
    cyc(0, 1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    cyc(1, 1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    cyc(0, 0, 1, 16'h0020, 16'hCAFE, 0, 0, 16'h0, 4'h0, 16'h0);
    cyc(0, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 4'h0, 16'h0);
    idle(2);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65520, 65535)) : 16'($urandom_range(0, 63));
      if (!hold && $urandom_range(0, 5) == 0) hold = 1;
      hrand = $urandom_range(0, 3) == 0;
      cyc($urandom_range(0, 499) == 0, r == 1 || r == 2, r == 3, a, 16'($urandom),
          hold || (bq.size() != 0 && hrand), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 2) == 0) ? 16'($urandom_range(65530, 65535)) : 16'($urandom_range(0, 63)),
          4'($urandom_range(0, 15)), 16'($urandom));
      if (bq.size() != 0) hold = 0;
    end
    idle(20);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (eq.size() == 0 && hq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d port and %0d read entries left, expected 0 and 0", eq.size(), hq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
